tb_write_scoreboard: RTL

Parametrised self-checking scoreboard for processor-level simulation. It snoops the data-memory write bus for stores to a test port. A begin symbol arms it. Each later store to the port is compared in order against a loadable expected-value table. It reports error count, run duration, first-mismatch details, timeout and pass/finish status. It sits beside the CPU/cache top in the bench and replaces hard-coded answer ROMs, so one block serves every program.

---
 rtl/tb_write_scoreboard.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tb_write_scoreboard.sv
// Snooping write scoreboard: a store to TEST_PORT carrying BEGIN_SYM arms it.
// Each later store to the port is checked in order against a loadable table.
module tb_write_scoreboard #(
    parameter int                ADDR_W     = 30,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT  = 30'h10,
    parameter logic [DATA_W-1:0] BEGIN_SYM  = 32'h00000168,
    parameter bit                SWAP_BYTES = 1'b1,
    parameter logic [15:0]       TIMEOUT    = 16'hFFFF,
    localparam int               IW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              exp_we,
    input  logic [IW-1:0]     exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IW:0]       check_num,
    input  logic              clr,
    output logic [7:0]        error_num,
    output logic [15:0]       duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic              first_err_valid,
    output logic [IW-1:0]     first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    function automatic logic [DATA_W-1:0] swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (SWAP_BYTES)
            for (int i = 0; i < DATA_W / 8; i++)
                r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    localparam logic [IW:0] DEPTH_V = (IW+1)'(DEPTH);

    state_t            state;
    logic              wen_q;
    logic [IW:0]       idx;
    logic [IW:0]       num_q;
    logic [DATA_W-1:0] tbl [DEPTH];

    logic              acc;
    logic [DATA_W-1:0] sdata;
    logic              arm;
    logic              checking;
    logic [IW:0]       idx_next;
    logic              mism;
    logic              done;
    logic [IW:0]       num_in;

    // A store held high across a cache stall is counted only on its first cycle.
    assign acc      = wen & ~wen_q & (addr == TEST_PORT);
    assign sdata    = swap(data);
    assign arm      = acc && (sdata == BEGIN_SYM) && (state != CHECK);
    assign checking = acc && (num_q != '0);
    assign idx_next = idx + (IW+1)'(1);
    assign mism     = tbl[idx[IW-1:0]] != sdata;
    assign done     = (num_q == '0) || (checking && (idx_next == num_q));
    assign num_in   = (check_num > DEPTH_V) ? DEPTH_V : check_num;

    assign finish = (state == REPORT);
    assign pass   = finish & ~timeout & (error_num == 8'd0);

    // Expected table: not reset, writable only while idle so a run sees stable values.
    always_ff @(posedge clk) begin
        if (state == IDLE && exp_we)
            tbl[exp_idx] <= exp_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            wen_q           <= 1'b0;
            idx             <= '0;
            num_q           <= '0;
            error_num       <= 8'hFF;
            duration        <= 16'd0;
            timeout         <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_data  <= '0;
        end else begin
            wen_q <= wen;
            if (clr) begin
                state           <= IDLE;
                idx             <= '0;
                error_num       <= 8'hFF;
                duration        <= 16'd0;
                timeout         <= 1'b0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_data  <= '0;
            end else if (arm) begin
                state           <= CHECK;
                idx             <= '0;
                num_q           <= num_in;
                error_num       <= 8'd0;
                duration        <= 16'd0;
                timeout         <= 1'b0;
                first_err_valid <= 1'b0;
            end else if (state == CHECK) begin
                duration <= sat_inc16(duration);
                if (checking) begin
                    idx <= idx_next;
                    if (mism) begin
                        error_num <= sat_inc8(error_num);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= idx[IW-1:0];
                            first_err_data  <= sdata;
                        end
                    end
                end
                // Completion wins over timeout when both land on the same edge.
                if (done) begin
                    state <= REPORT;
                end else if (duration == TIMEOUT - 16'd1) begin
                    state   <= REPORT;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
